// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a five-stage in-order CPU (F/D/E/M/W).
// Resolves three hazard types:
//   * data hazards    - operand forwarding from MEM/WB into EX, plus a
//                       one-bubble stall for load-use;
//   * control hazards - squashes wrong-path instructions on a taken branch,
//                       JALR or JAL;
//   * D-cache misses  - freezes the pipe while a miss is outstanding, then
//                       uses one DRAIN cycle to let the load move to WB.
//
// Ports
//   clk, CPU_RST          clock; asynchronous active-high reset
//   Rs1D/Rs2D             source registers of the instruction in ID
//   Rs1E/Rs2E, RegReadE   source registers in EX and which of them are used
//   RdE/RdM/RdW           destination registers in EX/MEM/WB
//   MemToRegE             the instruction in EX is a load
//   RegWriteM/RegWriteW   non-zero means a register write is pending
//   JalD, JalrE, BranchE  control-flow redirect sources
//   DCacheMiss            miss request (level)
//   DCacheDone            miss serviced (one-cycle pulse)
//   Stall*/Flush*         per-stage controls (en = ~StallX, clear = FlushX)
//   Forward1E/Forward2E   ALU operand select: 00 regfile, 10 MEM, 01 WB
//   MissCycles            registered count of cycles spent in MISS
//   MissTimeout           registered sticky flag: a miss lasted 255 cycles
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        CPU_RST,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic [1:0]  RegReadE,
  input  logic        MemToRegE,
  input  logic [2:0]  RegWriteM,
  input  logic [2:0]  RegWriteW,
  input  logic        JalD,
  input  logic        JalrE,
  input  logic        BranchE,
  input  logic        DCacheMiss,
  input  logic        DCacheDone,
  output logic        StallF,
  output logic        FlushF,
  output logic        StallD,
  output logic        FlushD,
  output logic        StallE,
  output logic        FlushE,
  output logic        StallM,
  output logic        FlushM,
  output logic        StallW,
  output logic        FlushW,
  output logic [1:0]  Forward1E,
  output logic [1:0]  Forward2E,
  output logic [31:0] MissCycles,
  output logic        MissTimeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MISS  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] miss_cycles_q, miss_cycles_d;
  logic [7:0]  miss_len_q, miss_len_d;
  logic        miss_timeout_q, miss_timeout_d;
  logic        lu_q, lu_d;          // a load-use bubble was inserted last cycle

  logic        load_use_s;
  logic        redirect_s;
  logic        timeout_hit_s;
  logic        miss_pattern_s;
  logic        lu_applied_s;

  // Operand source select: MEM result beats WB result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [2:0] wr_m,
    input logic [4:0] rd_m,
    input logic [2:0] wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (wr_m != 3'd0) && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (used && (wr_w != 3'd0) && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Saturating increment helpers.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // Hazard detection terms shared by the FSM and the output decode.
  always_comb begin
    load_use_s    = MemToRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    redirect_s    = BranchE || JalrE;
    // The length counter reaches 255 on this edge when it is 254 or already 255.
    timeout_hit_s = (state_q == MISS) && (miss_len_q >= 8'hFE);
  end

  // Next-state and counter logic for the D-cache miss FSM.
  always_comb begin
    state_d        = state_q;
    miss_len_d     = miss_len_q;
    miss_cycles_d  = miss_cycles_q;
    miss_timeout_d = miss_timeout_q;
    case (state_q)
      IDLE: begin
        if (DCacheMiss) begin
          state_d    = MISS;
          miss_len_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      MISS: begin
        miss_len_d    = sat_inc8(miss_len_q);
        miss_cycles_d = sat_inc32(miss_cycles_q);
        // A timed-out miss stays frozen in MISS until reset.
        if (DCacheDone && !miss_timeout_q && !timeout_hit_s) begin
          state_d = DRAIN;
        end else begin
          state_d = MISS;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (timeout_hit_s) begin
      miss_timeout_d = 1'b1;
    end else begin
      miss_timeout_d = miss_timeout_q;
    end
  end

  // Stall/flush/forward decode, combinational from inputs and state.
  always_comb begin
    StallF         = 1'b0;
    FlushF         = 1'b0;
    StallD         = 1'b0;
    FlushD         = 1'b0;
    StallE         = 1'b0;
    FlushE         = 1'b0;
    StallM         = 1'b0;
    FlushM         = 1'b0;
    StallW         = 1'b0;
    FlushW         = 1'b0;
    Forward1E      = 2'b00;
    Forward2E      = 2'b00;
    lu_applied_s   = 1'b0;
    // Miss entry is combinational so the stage holding the load never advances.
    miss_pattern_s = (state_q == MISS) || ((state_q == IDLE) && DCacheMiss);

    if (CPU_RST) begin
      FlushF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      Forward1E = fwd_sel(RegReadE[1], Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      Forward2E = fwd_sel(RegReadE[0], Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      if (miss_pattern_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (state_q == DRAIN) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else if (redirect_s) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        FlushD = JalD;
        // After one bubble the load has left EX in a real pipe; lu_q keeps
        // the bubble to exactly one cycle even if the inputs linger.
        if (load_use_s && !lu_q) begin
          StallF       = 1'b1;
          StallD       = 1'b1;
          FlushE       = 1'b1;
          lu_applied_s = 1'b1;
        end else begin
          lu_applied_s = 1'b0;
        end
      end
    end
    lu_d = lu_applied_s;
  end

  // State, counter and flag registers.
  always_ff @(posedge clk or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q        <= IDLE;
      miss_len_q     <= 8'd0;
      miss_cycles_q  <= 32'd0;
      miss_timeout_q <= 1'b0;
      lu_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      miss_len_q     <= miss_len_d;
      miss_cycles_q  <= miss_cycles_d;
      miss_timeout_q <= miss_timeout_d;
      lu_q           <= lu_d;
    end
  end

  assign MissCycles  = miss_cycles_q;
  assign MissTimeout = miss_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge. The ten stage
// controls are packed {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,
// FlushM,StallW,FlushW} and compared against hand-written patterns.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        CPU_RST;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  RegReadE;
  logic        MemToRegE;
  logic [2:0]  RegWriteM, RegWriteW;
  logic        JalD, JalrE, BranchE, DCacheMiss, DCacheDone;
  logic        StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic        StallM, FlushM, StallW, FlushW;
  logic [1:0]  Forward1E, Forward2E;
  logic [31:0] MissCycles;
  logic        MissTimeout;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] C_NONE   = 10'b00_00_00_00_00;
  localparam logic [9:0] C_RESET  = 10'b01_01_01_01_01;
  localparam logic [9:0] C_MISS   = 10'b10_10_10_10_01;
  localparam logic [9:0] C_DRAIN  = 10'b10_10_10_00_00;
  localparam logic [9:0] C_LDUSE  = 10'b10_10_01_00_00;
  localparam logic [9:0] C_BRANCH = 10'b00_01_01_00_00;
  localparam logic [9:0] C_JAL    = 10'b00_01_00_00_00;

  logic [9:0] ctl;
  assign ctl = {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW};

  hazard_ctrl dut (
    .clk(clk), .CPU_RST(CPU_RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadE(RegReadE), .MemToRegE(MemToRegE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .JalD(JalD), .JalrE(JalrE), .BranchE(BranchE),
    .DCacheMiss(DCacheMiss), .DCacheDone(DCacheDone),
    .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
    .StallW(StallW), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E),
    .MissCycles(MissCycles), .MissTimeout(MissTimeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_at_neg(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(ctl), 32'(exp));
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegReadE = 2'b00; MemToRegE = 1'b0;
    RegWriteM = 3'd0; RegWriteW = 3'd0;
    JalD = 1'b0; JalrE = 1'b0; BranchE = 1'b0;
    DCacheMiss = 1'b0; DCacheDone = 1'b0;
  endtask

  initial begin
    CPU_RST = 1'b1;
    clear_inputs();
    // Reset state: forwarding-worthy inputs must still give 00.
    RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 3'b010; RegReadE = 2'b10;
    #2;
    ctl_at_neg("rst_ctl", C_RESET);
    check_eq("rst_fwd1", 32'(Forward1E), 32'd0);
    check_eq("rst_cycles", MissCycles, 32'd0);
    check_eq("rst_timeout", 32'(MissTimeout), 32'd0);
    CPU_RST = 1'b0;
    clear_inputs();
    tick();
    ctl_at_neg("idle_ctl", C_NONE);

    // Forwarding priority, MEM over WB, then WB when MEM is x0.
    tick();
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    RegWriteM = 3'b010; RegWriteW = 3'b010; RegReadE = 2'b10;
    @(negedge clk);
    check_eq("fwd1_mem", 32'(Forward1E), 32'd2);
    check_eq("fwd2_unused", 32'(Forward2E), 32'd0);
    RdM = 5'd0;
    #1;
    check_eq("fwd1_wb", 32'(Forward1E), 32'd1);
    RdM = 5'd5; RegReadE = 2'b01;
    #1;
    check_eq("fwd2_mem", 32'(Forward2E), 32'd2);
    check_eq("fwd1_unused", 32'(Forward1E), 32'd0);
    RegWriteM = 3'd0;
    #1;
    check_eq("fwd2_wb", 32'(Forward2E), 32'd1);

    // x0 guard on forwarding and load-use.
    clear_inputs();
    RdM = 5'd0; Rs1E = 5'd0; RegWriteM = 3'b001; RegReadE = 2'b10;
    RdW = 5'd3; RegWriteW = 3'b001;
    MemToRegE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    check_eq("x0_fwd1", 32'(Forward1E), 32'd0);
    check_eq("x0_lduse", 32'(ctl), 32'(C_NONE));

    // Load-use: one bubble, then the same inputs no longer stall.
    tick();
    clear_inputs();
    MemToRegE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    ctl_at_neg("lduse_1", C_LDUSE);
    tick();
    ctl_at_neg("lduse_2", C_NONE);
    tick();
    BranchE = 1'b1;
    ctl_at_neg("lduse_branch", C_BRANCH);
    tick();
    clear_inputs();
    JalD = 1'b1;
    ctl_at_neg("jal", C_JAL);
    BranchE = 1'b1;
    #1;
    check_eq("jal_branch", 32'(ctl), 32'(C_BRANCH));
    BranchE = 1'b0; JalrE = 1'b1; JalD = 1'b0;
    #1;
    check_eq("jalr", 32'(ctl), 32'(C_BRANCH));

    // DCacheDone outside MISS is ignored.
    tick();
    clear_inputs();
    DCacheDone = 1'b1;
    ctl_at_neg("done_idle", C_NONE);
    tick();
    DCacheDone = 1'b0;
    ctl_at_neg("done_idle_after", C_NONE);

    // Miss for 4 cycles, then a done pulse.
    tick();
    DCacheMiss = 1'b1;
    ctl_at_neg("miss_entry", C_MISS);
    for (int i = 0; i < 3; i++) begin
      tick();
      ctl_at_neg("miss_hold", C_MISS);
    end
    tick();
    DCacheMiss = 1'b0; DCacheDone = 1'b1;
    ctl_at_neg("miss_done", C_MISS);
    tick();
    DCacheDone = 1'b0;
    ctl_at_neg("drain", C_DRAIN);
    check_eq("miss_cycles4", MissCycles, 32'd4);
    tick();
    ctl_at_neg("back_idle", C_NONE);
    check_eq("miss_cycles_hold", MissCycles, 32'd4);

    // Miss and done together while in MISS go to DRAIN.
    tick();
    DCacheMiss = 1'b1;
    tick();
    DCacheDone = 1'b1;
    ctl_at_neg("both_in_miss", C_MISS);
    tick();
    DCacheMiss = 1'b0; DCacheDone = 1'b0;
    ctl_at_neg("both_drain", C_DRAIN);
    check_eq("miss_cycles5", MissCycles, 32'd5);

    // Reset mid-MISS returns to IDLE with no DRAIN.
    tick();
    DCacheMiss = 1'b1;
    tick();
    tick();
    DCacheMiss = 1'b0;
    ctl_at_neg("pre_rst_miss", C_MISS);
    CPU_RST = 1'b1;
    #1;
    check_eq("midmiss_rst_ctl", 32'(ctl), 32'(C_RESET));
    check_eq("midmiss_rst_cycles", MissCycles, 32'd0);
    CPU_RST = 1'b0;
    #1;
    check_eq("rst_release_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    ctl_at_neg("no_drain_after_rst", C_NONE);

    // Timeout: 255 MISS cycles set the sticky flag and freeze in MISS.
    tick();
    DCacheMiss = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check_eq("timeout_pre", 32'(MissTimeout), 32'd0);
    check_eq("cycles_254", MissCycles, 32'd254);
    tick();
    check_eq("timeout_set", 32'(MissTimeout), 32'd1);
    check_eq("cycles_255", MissCycles, 32'd255);
    DCacheDone = 1'b1;
    tick();
    DCacheDone = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    DCacheMiss = 1'b0;
    ctl_at_neg("timeout_stuck", C_MISS);
    check_eq("timeout_sticky", 32'(MissTimeout), 32'd1);
    CPU_RST = 1'b1;
    #1;
    check_eq("timeout_rst", 32'(MissTimeout), 32'd0);
    CPU_RST = 1'b0;
    #1;
    check_eq("final_idle", 32'(ctl), 32'(C_NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
